// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory port arbiter.
// Word-index width is exported for the memory wrapper that sits beside the arbiter.
package imem_pkg;

    localparam int unsigned IMEM_DEPTH = 64;
    localparam int unsigned IMEM_AW    = $clog2(IMEM_DEPTH);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FORCE
    } arb_state_t;

    // True when the word index of a byte address falls inside a memory of `depth` words.
    function automatic logic word_in_range(input logic [31:0] addr, input int unsigned depth);
        return {2'b00, addr[31:2]} < depth;
    endfunction

endpackage

// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction memory between CPU fetch and the program loader:
// boot-time loading, fetch-priority arbitration in run mode, and a starvation guard.
module imem_port_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH    = IMEM_DEPTH,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_gnt,
    output logic [31:0] fetch_rdata,
    input  logic        load_valid,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        load_ready,
    input  logic        load_done,
    output logic        cpu_run,
    output logic        load_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CntW = $clog2(MAX_WAIT) + 1;
    localparam logic [CntW-1:0] WaitLast = CntW'(MAX_WAIT - 1);

    arb_state_t      state_q, state_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            load_err_q, load_err_d;
    logic            in_range;

    assign in_range    = word_in_range(load_addr, DEPTH);
    assign fetch_rdata = mem_rdata;
    assign cpu_run     = rst_n && (state_q != BOOT);
    assign load_err    = load_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            wait_cnt_q <= '0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            load_err_q <= load_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        load_err_d = load_err_q;
        fetch_gnt  = 1'b0;
        load_ready = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = load_addr;
        mem_wdata  = load_data;

        unique case (state_q)
            BOOT: begin
                load_ready = 1'b1;
                mem_we     = load_valid && in_range;
                if (load_done) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (fetch_req) begin
                    mem_addr  = fetch_addr;
                    fetch_gnt = 1'b1;
                    if (load_valid) begin
                        if (wait_cnt_q != '1) begin
                            wait_cnt_d = wait_cnt_q + 1'b1;
                        end
                        if (wait_cnt_q >= WaitLast) begin
                            state_d = FORCE;
                        end
                    end
                end else if (load_valid) begin
                    load_ready = 1'b1;
                    mem_we     = in_range;
                    wait_cnt_d = '0;
                end
            end
            FORCE: begin
                // One cycle of loader ownership; the CPU sees fetch_gnt low and stalls.
                load_ready = 1'b1;
                mem_we     = load_valid && in_range;
                wait_cnt_d = '0;
                state_d    = RUN;
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        if (load_valid && load_ready && !in_range) begin
            load_err_d = 1'b1;
        end

        // Port outputs are held quiet for as long as reset is asserted.
        if (!rst_n) begin
            fetch_gnt  = 1'b0;
            load_ready = 1'b0;
            mem_we     = 1'b0;
            mem_addr   = '0;
            mem_wdata  = '0;
        end
    end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single-port instruction memory (asynchronous word-aligned read, synchronous write) between two requesters: the CPU fetch stage and the program loader (host/debug write path).
- Sequences boot: holds the CPU off while the loader fills the program, then releases it.
- In run mode, arbitrates fetch against late loader writes, with a starvation guard.
- Sits between the fetch stage, the loader interface and the instruction memory wrapper.

Parameters:
- DEPTH, 64, number of 32-bit words in instruction memory.
- MAX_WAIT, 8, cycles a pending loader write may be blocked by fetch in RUN before it is forced through.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- fetch_req  in  1  CPU requests an instruction this cycle.
- fetch_addr  in  32  byte address; word index = fetch_addr[31:2].
- fetch_gnt  out  1  fetch_rdata valid this cycle; CPU must stall its PC when low with fetch_req high.
- fetch_rdata  out  32  instruction word.
- load_valid  in  1  loader write pending.
- load_addr  in  32  byte address of loader write.
- load_data  in  32  word to write.
- load_ready  out  1  write accepted this cycle (valid and ready both high).
- load_done  in  1  single-cycle pulse: program complete.
- cpu_run  out  1  CPU enable; 0 holds the core.
- load_err  out  1  sticky: an out-of-range loader write was seen.
- mem_addr  out  32  byte address to memory.
- mem_we  out  1  memory write enable.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data (combinational from mem_addr).

Behaviour:
- Reset (rst_n=0 at clock edge), values held while reset is asserted:
  - state=BOOT; cpu_run=0; load_err=0; wait_cnt=0.
  - fetch_gnt=0, load_ready=0, mem_we=0.
  - mem_addr=0, mem_wdata=0.
- Reset asserted in any state, including mid-load, returns to BOOT next edge. Writes already committed are not undone.
- State BOOT:
  - load_ready=1 combinationally.
  - mem_addr=load_addr, mem_wdata=load_data.
  - mem_we=load_valid && in-range.
  - fetch_gnt=0.
  - load_done=1 → RUN next cycle. A simultaneous load_valid is still accepted that cycle.
- State RUN:
  - cpu_run=1.
  - fetch priority: if fetch_req, mem_addr=fetch_addr, fetch_gnt=1, load_ready=0.
  - If load_valid && fetch_req, increment wait_cnt (saturating).
  - If load_valid && !fetch_req: loader write goes through that cycle (load_ready=1, mem_we per range rule) and wait_cnt clears to 0.
  - When wait_cnt reaches MAX_WAIT-1 with load_valid and fetch_req both high → FORCE next cycle.
- State FORCE (exactly 1 cycle):
  - Loader owns the port: load_ready=1, mem_we per range rule, fetch_gnt=0 (CPU stalls).
  - wait_cnt cleared; return to RUN.
  - If load_valid has dropped, the cycle is spent idle and returns to RUN.
- State transitions: load_done outside BOOT is ignored. There is no path back to BOOT except reset.
- Range rule:
  - In range means load_addr[31:2] < DEPTH.
  - An out-of-range write is accepted (load_ready=1) but mem_we=0, and load_err is set sticky until reset.
- Alignment: load_addr[1:0] is ignored; the address is forwarded unchanged, and the memory uses [31:2].
- fetch_rdata = mem_rdata, always; it is meaningful only with fetch_gnt=1.
- Latency:
  - Fetch: zero cycles (combinational grant and data).
  - Loader write: commits at the clock edge of the accepting cycle.
- wait_cnt: width $clog2(MAX_WAIT)+1, saturating, never wraps.

Decomposition:
- Shared package imem_pkg:
  - typedef enum logic [1:0] {BOOT, RUN, FORCE} arb_state_t.
  - IMEM_DEPTH=64, localparam word-index width.
- No sub-module needed: the starvation counter is inline.
- The instruction memory wrapper is instantiated by the parent, not inside this block.

Test Plan:
- Reset, then load_valid writes 0xE3A0101E to addr 0x4 and 0xE3A02011 to 0x8, then load_done → both words present at those addresses in memory; cpu_run=0 until the cycle after load_done, then 1; fetch_gnt=0 throughout BOOT.
- RUN: fetch_req=1 with fetch_addr 0x4 → fetch_gnt=1 and fetch_rdata=0xE3A0101E in the same cycle.
- RUN: fetch_req held high, load_valid high at addr 0xC, MAX_WAIT=8 → load_ready=0 for 8 cycles. FORCE on cycle 9: load_ready=1, fetch_gnt=0, word written. fetch_gnt=1 again on cycle 10.
- RUN: load_valid with fetch_req=0 → accepted the same cycle, wait_cnt=0.
- Loader write to addr 0x100 (word 64 ≥ DEPTH) → load_ready=1, mem_we=0, load_err=1 and stays 1 until rst_n=0.
- rst_n=0 during FORCE → next state BOOT, cpu_run=0, load_err=0. Memory contents written earlier are intact on read-back after a new load_done.
